// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - parametrised streaming CRC generator/checker
// Absorbs DATA_W-bit beats (lane 0 first) and holds the final CRC in a result slot.
module crc_stream_engine #(
  parameter int               CRC_W       = 16,
  parameter logic [CRC_W-1:0] POLY        = 16'h1021,
  parameter logic [CRC_W-1:0] INIT        = 16'hFFFF,
  parameter int               DATA_W      = 8,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0,
  parameter logic [CRC_W-1:0] XOR_OUT     = '0,
  parameter logic [CRC_W-1:0] RESIDUE     = '0,
  localparam int              BYTES       = DATA_W / 8,
  localparam int              BW          = $clog2(BYTES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_last,
  input  logic [BW-1:0]     in_bytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_ok,
  output logic              busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [BW-1:0] BYTES_L = BW'(BYTES);

  state_t           state;
  logic [CRC_W-1:0] acc;
  logic [CRC_W-1:0] next_crc;
  logic [CRC_W-1:0] result;
  logic             accept;
  logic             use_partial;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int k = 0; k < CRC_W; k++) r[k] = c[CRC_W-1-k];
    return r;
  endfunction

  // MSB-first bitwise LFSR step over one byte.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] b);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      fb = r[CRC_W-1] ^ b[k];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  assign in_ready    = (~out_valid | out_ready) & ~init;
  assign accept      = in_valid & in_ready;
  assign busy        = (state == ACTIVE);
  // in_bytes of 0 or >= BYTES selects every lane.
  assign use_partial = in_last && (in_bytes != '0) && (in_bytes < BYTES_L);

  always_comb begin
    next_crc = acc;
    for (int i = 0; i < BYTES; i++) begin
      if (!use_partial || (BW'(i) < in_bytes))
        next_crc = crc_byte(next_crc, REFLECT_IN ? rev8(data_in[8*i +: 8]) : data_in[8*i +: 8]);
    end
  end

  assign result = (REFLECT_OUT ? rev_crc(next_crc) : next_crc) ^ XOR_OUT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= INIT;
      out_valid <= 1'b0;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (init) begin
        state <= IDLE;
        acc   <= INIT;
      end else if (accept) begin
        if (in_last) begin
          state     <= IDLE;
          acc       <= INIT;
          crc_out   <= result;
          crc_ok    <= (result == RESIDUE);
          out_valid <= 1'b1;
        end else begin
          state <= ACTIVE;
          acc   <= next_crc;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - directed bench for crc_stream_engine
// Three instances: CCITT byte-wide, CCITT 32-bit beats, reflected CRC-32.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // CCITT-FALSE, 8-bit beats
  logic        a_init, a_valid, a_ready, a_last, a_ovalid, a_oready, a_ok, a_busy;
  logic [7:0]  a_data;
  logic [0:0]  a_bytes;
  logic [15:0] a_crc;

  // CCITT-FALSE, 32-bit beats
  logic        b_init, b_valid, b_ready, b_last, b_ovalid, b_oready, b_ok, b_busy;
  logic [31:0] b_data;
  logic [2:0]  b_bytes;
  logic [15:0] b_crc;

  // CRC-32 (reflected), 8-bit beats
  logic        c_init, c_valid, c_ready, c_last, c_ovalid, c_oready, c_ok, c_busy;
  logic [7:0]  c_data;
  logic [0:0]  c_bytes;
  logic [31:0] c_crc;

  crc_stream_engine u_a (
    .clk(clk), .reset(reset), .init(a_init), .in_valid(a_valid), .in_ready(a_ready),
    .data_in(a_data), .in_last(a_last), .in_bytes(a_bytes), .out_valid(a_ovalid),
    .out_ready(a_oready), .crc_out(a_crc), .crc_ok(a_ok), .busy(a_busy)
  );

  crc_stream_engine #(.DATA_W(32)) u_b (
    .clk(clk), .reset(reset), .init(b_init), .in_valid(b_valid), .in_ready(b_ready),
    .data_in(b_data), .in_last(b_last), .in_bytes(b_bytes), .out_valid(b_ovalid),
    .out_ready(b_oready), .crc_out(b_crc), .crc_ok(b_ok), .busy(b_busy)
  );

  crc_stream_engine #(
    .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .DATA_W(8),
    .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .XOR_OUT(32'hFFFFFFFF), .RESIDUE(32'h2144DF1C)
  ) u_c (
    .clk(clk), .reset(reset), .init(c_init), .in_valid(c_valid), .in_ready(c_ready),
    .data_in(c_data), .in_last(c_last), .in_bytes(c_bytes), .out_valid(c_ovalid),
    .out_ready(c_oready), .crc_out(c_crc), .crc_ok(c_ok), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_beat(input logic [7:0] d, input logic last);
    int n = 0;
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    chk("a_ready_wait", a_ready, 1'b1);
    a_data = d; a_last = last; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic c_beat(input logic [7:0] d, input logic last);
    int n = 0;
    while (!c_ready && n < 50) begin @(negedge clk); n++; end
    chk("c_ready_wait", c_ready, 1'b1);
    c_data = d; c_last = last; c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0; c_last = 1'b0;
  endtask

  task automatic b_beat(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int n = 0;
    while (!b_ready && n < 50) begin @(negedge clk); n++; end
    chk("b_ready_wait", b_ready, 1'b1);
    b_data = d; b_last = last; b_bytes = nb; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic a_str(input string s, input logic last);
    for (int i = 0; i < s.len(); i++) a_beat(s[i], last && (i == s.len() - 1));
  endtask

  task automatic c_str(input string s, input logic last);
    for (int i = 0; i < s.len(); i++) c_beat(s[i], last && (i == s.len() - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_init = 0; a_valid = 0; a_last = 0; a_data = 0; a_bytes = 0; a_oready = 1;
    b_init = 0; b_valid = 0; b_last = 0; b_data = 0; b_bytes = 0; b_oready = 1;
    c_init = 0; c_valid = 0; c_last = 0; c_data = 0; c_bytes = 0; c_oready = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_a_ovalid", a_ovalid, 1'b0);
    chk("rst_a_crc", a_crc, 16'h0000);
    chk("rst_a_ok", a_ok, 1'b0);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_a_ready", a_ready, 1'b1);
    chk("rst_c_crc", c_crc, 32'h0);

    // CCITT check value, then frame including its own CRC
    a_str("12345678", 1'b0);
    chk("a_busy_mid", a_busy, 1'b1);
    a_beat("9", 1'b1);
    chk("a_f1_ovalid", a_ovalid, 1'b1);
    chk("a_f1_crc", a_crc, 16'h29B1);
    chk("a_f1_ok", a_ok, 1'b0);
    chk("a_f1_busy", a_busy, 1'b0);
    a_str("123456789", 1'b0);
    a_beat(8'h29, 1'b0);
    a_beat(8'hB1, 1'b1);
    chk("a_f2_crc", a_crc, 16'h0000);
    chk("a_f2_ok", a_ok, 1'b1);
    @(negedge clk);
    chk("a_f2_drain", a_ovalid, 1'b0);

    // init abort after 4 bytes, then full frame with idle gaps
    a_str("1234", 1'b0);
    chk("a_busy_pre_init", a_busy, 1'b1);
    a_init = 1'b1; a_valid = 1'b1; a_data = "5";
    #1;
    chk("a_ready_init", a_ready, 1'b0);
    @(negedge clk);
    a_init = 1'b0; a_valid = 1'b0;
    chk("a_busy_post_init", a_busy, 1'b0);
    chk("a_init_no_out", a_ovalid, 1'b0);
    a_str("1234", 1'b0);
    repeat (2) @(negedge clk);
    a_str("56789", 1'b1);
    chk("a_abort_crc", a_crc, 16'h29B1);
    chk("a_abort_ovalid", a_ovalid, 1'b1);

    // 32-bit beats, partial last beat; hold result slot
    b_oready = 1'b0;
    b_beat(32'h34333231, 1'b0, 3'd0);
    b_beat(32'h38373635, 1'b0, 3'd0);
    chk("b_busy_mid", b_busy, 1'b1);
    b_beat(32'h00B12939, 1'b1, 3'd1);
    chk("b_part_ovalid", b_ovalid, 1'b1);
    chk("b_part_crc", b_crc, 16'h29B1);
    chk("b_bp_ready", b_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk("b_hold_crc", b_crc, 16'h29B1);
    chk("b_hold_ovalid", b_ovalid, 1'b1);
    // single-beat frame 0x00 accepted on the same edge the slot drains
    b_oready = 1'b1; b_data = 32'h0; b_last = 1'b1; b_bytes = 3'd1; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0; b_last = 1'b0;
    chk("b_reload_ovalid", b_ovalid, 1'b1);
    chk("b_reload_crc", b_crc, 16'hE1F0);
    chk("b_reload_busy", b_busy, 1'b0);
    @(negedge clk);
    chk("b_drain", b_ovalid, 1'b0);
    // full last beat: "123456789",29,B1,00 leaves a zero register
    b_beat(32'h34333231, 1'b0, 3'd0);
    b_beat(32'h38373635, 1'b0, 3'd0);
    b_beat(32'h00B12939, 1'b1, 3'd0);
    chk("b_full0_crc", b_crc, 16'h0000);
    chk("b_full0_ok", b_ok, 1'b1);
    b_beat(32'h34333231, 1'b0, 3'd0);
    b_beat(32'h38373635, 1'b0, 3'd0);
    b_beat(32'h00B12939, 1'b1, 3'd4);
    chk("b_full4_crc", b_crc, 16'h0000);
    b_beat(32'h34333231, 1'b0, 3'd0);
    b_beat(32'h38373635, 1'b0, 3'd0);
    b_beat(32'h00B12939, 1'b1, 3'd7);
    chk("b_full7_crc", b_crc, 16'h0000);
    chk("b_full7_ok", b_ok, 1'b1);

    // reflected CRC-32
    c_str("123456789", 1'b1);
    chk("c_chk_crc", c_crc, 32'hCBF43926);
    chk("c_chk_ok", c_ok, 1'b0);
    c_str("023456789", 1'b0);
    c_beat(8'h26, 1'b0); c_beat(8'h39, 1'b0); c_beat(8'hF4, 1'b0); c_beat(8'hCB, 1'b1);
    chk("c_bad_ok", c_ok, 1'b0);
    c_beat("1", 1'b0);
    c_oready = 1'b0;
    c_str("23456789", 1'b0);
    c_beat(8'h26, 1'b0); c_beat(8'h39, 1'b0); c_beat(8'hF4, 1'b0); c_beat(8'hCB, 1'b1);
    chk("c_res_crc", c_crc, 32'h2144DF1C);
    chk("c_res_ok", c_ok, 1'b1);

    // asynchronous reset between clock edges
    a_oready = 1'b1;
    @(negedge clk);
    a_str("1234", 1'b0);
    chk("a_busy_pre_rst", a_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_a_busy", a_busy, 1'b0);
    chk("arst_a_ovalid", a_ovalid, 1'b0);
    chk("arst_a_crc", a_crc, 16'h0000);
    chk("arst_c_ovalid", c_ovalid, 1'b0);
    chk("arst_c_crc", c_crc, 32'h0);
    chk("arst_c_ok", c_ok, 1'b0);
    chk("arst_c_ready", c_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    c_oready = 1'b1;
    @(negedge clk);
    chk("post_rst_a_ovalid", a_ovalid, 1'b0);
    a_str("123456789", 1'b1);
    chk("post_rst_a_crc", a_crc, 16'h29B1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised streaming CRC generator/checker. It absorbs a frame as DATA_W-bit beats under a valid/ready handshake, processes DATA_W/8 bytes per clock, and presents the final CRC plus a residue-check flag in a held output slot. It generalises the fixed CCITT byte-wide parallel CRC to any polynomial and width, multi-byte beats, partial last beats, reflection and final XOR. It sits between a framed byte/word stream and the link or packet logic that appends or checks a frame CRC.

## Interface
- CRC_W, 16: CRC width, 8..32.
- POLY, 16'h1021: generator polynomial in normal form, implicit x^CRC_W term.
- INIT, 16'hFFFF: accumulator value at frame start.
- DATA_W, 8: beat width, a multiple of 8. BYTES = DATA_W/8.
- REFLECT_IN, 0: 1 bit-reverses each input byte before processing.
- REFLECT_OUT, 0: 1 bit-reverses the whole CRC_W result.
- XOR_OUT, 0: value XORed onto the result after REFLECT_OUT.
- RESIDUE, 0: expected crc_out value when a frame that includes its own CRC is correct.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  synchronous abort: reloads the accumulator to INIT.
- in_valid  input  1  beat offered.
- in_ready  output  1  beat can be accepted.
- data_in  input  DATA_W  beat data. Lane 0 = data_in[7:0] is processed first.
- in_last  input  1  beat is the last of its frame.
- in_bytes  input  $clog2(BYTES+1)  number of valid lanes on a last beat. 0 or any value >BYTES means BYTES. Ignored when in_last=0.
- out_valid  output  1  result slot full.
- out_ready  input  1  consumer takes the result.
- crc_out  output  CRC_W  final CRC of the frame.
- crc_ok  output  1  crc_out == RESIDUE.
- busy  output  1  a frame is in progress (FSM in ACTIVE).

## Operation
- Accept condition: in_valid & in_ready.
- in_ready = (~out_valid | out_ready) & ~init.
- Accumulator update is an unrolled MSB-first bitwise LFSR over the valid lanes, in order lane 0..n-1. Each lane contributes 8 bits, MSB first after the optional reflection. The update is combinational and completes within a single cycle.
- FSM states:
  - IDLE: reset state; accumulator = INIT; busy=0.
  - ACTIVE: a non-last beat has been accepted; busy=1.
- FSM transitions:
  - IDLE -> ACTIVE on acceptance of a non-last beat.
  - ACTIVE/IDLE -> IDLE on acceptance of a last beat.
  - Any state -> IDLE on init.
- A single-beat frame (in_last on the first beat) goes IDLE -> IDLE.
- Last-beat acceptance, all on the same edge:
  - crc_out <= (REFLECT_OUT ? rev(next) : next) ^ XOR_OUT.
  - crc_ok <= that value == RESIDUE.
  - out_valid <= 1.
  - accumulator <= INIT.
  This means the next frame's first beat can be accepted on the following cycle.
- Output slot handshake:
  - out_valid clears on out_valid & out_ready unless a new last beat is accepted on the same edge; in that case the slot reloads and out_valid stays 1.
  - crc_out and crc_ok hold their values while out_valid=1 and until the slot is reloaded.
- init behaviour:
  - Aborts the frame in progress and forces IDLE and accumulator=INIT.
  - Does not touch the output slot.
  - A beat presented in the same cycle is not accepted, because in_ready=0.
- Reset values: accumulator=INIT, state IDLE, busy=0, out_valid=0, crc_out=0, crc_ok=0, in_ready=1 once reset is released and init=0.

## Timing
- Latency: out_valid rises on the first edge after the last beat is accepted (1 cycle).
- Throughput: BYTES bytes per clock, with no bubble between frames as long as the result slot drains.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0. This covers mid-frame beats as well as last beats.
- Reset asserted mid-frame clears all state immediately, with no clock required. The partial frame is lost and no out_valid is produced for it.
- in_valid=0 cycles inside a frame leave the accumulator and state unchanged.

## Test plan
- CRC_W=16, POLY=1021, INIT=FFFF, DATA_W=8, reflections off, XOR_OUT=0: ASCII "123456789", last on '9' -> 1 cycle later out_valid=1, crc_out=16'h29B1, crc_ok=0. Then frame "123456789",8'h29,8'hB1 -> crc_out=16'h0000, crc_ok=1.
- Same CRC, DATA_W=32: beats "1234", "5678", then "9" with in_last=1 and in_bytes=1 -> crc_out=16'h29B1. Repeat with in_bytes=0 on a 4-byte last beat; the result must match the all-lanes reference.
- CRC_W=32, POLY=04C11DB7, INIT=FFFFFFFF, REFLECT_IN=1, REFLECT_OUT=1, XOR_OUT=FFFFFFFF, RESIDUE=2144DF1C, DATA_W=8:
  - "123456789" -> crc_out=32'hCBF43926.
  - Appending bytes 26,39,F4,CB -> crc_ok=1.
  - Corrupting one bit -> crc_ok=0.
- Backpressure: hold out_ready=0 after frame 1 -> in_ready=0 and crc_out stays stable. Raise out_ready together with frame 2's last beat -> out_valid stays 1 and crc_out updates to frame 2's result.
- Abort paths:
  - Assert init after 4 bytes of "123456789", then send the full frame -> 16'h29B1.
  - Assert reset asynchronously mid-frame -> all outputs reach their reset values before the next clock edge.
